// File: rtl/count_window_sampler.sv
// Windowed count sampler: emits count_in growth per window_len cycles
// on a valid/ready output. Optional peak tracker: COUNT_WINDOW_SAMPLER_PEAK_EN.
//
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   count_in          : running upstream count
//   start, stop       : arm / end windowed sampling (stop has priority)
//   window_len        : window length in cycles, latched on accepted start
//   clear_overrun     : clears sticky overrun
//   delta_data/valid  : sample output, delta_ready accepts it
//   busy              : sampling in progress
//   overrun           : sticky, a sample was dropped
//   peak_delta        : (PEAK_EN) max delta loaded since rst/peak_clear
//   peak_clear        : (PEAK_EN) resets peak_delta

module count_window_sampler #(
  parameter int COUNTER_WIDTH = 32,
  parameter int WINDOW_WIDTH  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] count_in,
  input  logic                     start,
  input  logic                     stop,
  input  logic [WINDOW_WIDTH-1:0]  window_len,
  input  logic                     clear_overrun,
  output logic [COUNTER_WIDTH-1:0] delta_data,
  output logic                     delta_valid,
  input  logic                     delta_ready,
  output logic                     busy,
`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
  output logic [COUNTER_WIDTH-1:0] peak_delta,
  input  logic                     peak_clear,
`endif
  output logic                     overrun
);

  typedef enum logic {
    IDLE    = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t                   state_q, state_d;
  logic [WINDOW_WIDTH-1:0]  len_q, len_d;
  logic [WINDOW_WIDTH-1:0]  timer_q, timer_d;
  logic [COUNTER_WIDTH-1:0] base_q, base_d;
  logic [COUNTER_WIDTH-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;

  logic                     win_end;
  logic                     xfer;
  logic                     load;
  logic                     drop;
  logic [COUNTER_WIDTH-1:0] delta;

  // Modular subtraction makes upstream counter wrap transparent.
  assign delta   = count_in - base_q;
  assign win_end = (state_q == RUNNING) &&
                   (timer_q == len_q - WINDOW_WIDTH'(1));
  assign xfer    = valid_q && delta_ready;
  assign load    = win_end && (!valid_q || delta_ready);
  assign drop    = win_end && !load;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    timer_d = timer_q;
    base_d  = base_q;
    unique case (state_q)
      IDLE: begin
        if (start && !stop) begin
          len_d   = (window_len == '0) ? WINDOW_WIDTH'(1) : window_len;
          base_d  = count_in;
          timer_d = '0;
          state_d = RUNNING;
        end
      end
      RUNNING: begin
        if (win_end) begin
          base_d  = count_in;
          timer_d = '0;
        end else begin
          timer_d = timer_q + WINDOW_WIDTH'(1);
        end
        // Partial window is discarded; a window-end sample still loads.
        if (stop) begin
          timer_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load) begin
      data_d  = delta;
      valid_d = 1'b1;
    end else if (xfer) begin
      valid_d = 1'b0;
    end
    if (clear_overrun) ovr_d = 1'b0;
    if (drop)          ovr_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= WINDOW_WIDTH'(1);
      timer_q <= '0;
      base_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      base_q  <= base_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign delta_data  = data_q;
  assign delta_valid = valid_q;
  assign busy        = (state_q == RUNNING);
  assign overrun     = ovr_q;

`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
  logic [COUNTER_WIDTH-1:0] peak_q, peak_d;

  // Only loaded samples count; a clear coinciding with a load keeps it.
  always_comb begin
    peak_d = peak_q;
    if (peak_clear) peak_d = '0;
    if (load && (peak_clear || delta > peak_q)) peak_d = delta;
  end

  always_ff @(posedge clk) begin
    if (rst) peak_q <= '0;
    else     peak_q <= peak_d;
  end

  assign peak_delta = peak_q;
`endif

endmodule

// File: tb/tb_count_window_sampler.sv
// Directed bench for count_window_sampler.
// Inputs change 1 time unit after each rising edge; outputs sampled there.

module tb_count_window_sampler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] count_in = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] window_len = '0;
  logic        clear_overrun = 1'b0;
  logic [31:0] delta_data;
  logic        delta_valid;
  logic        delta_ready = 1'b0;
  logic        busy;
  logic        overrun;
`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
  logic [31:0] peak_delta;
  logic        peak_clear = 1'b0;
`endif

  logic [31:0] inc = '0;
  int checks = 0;
  int errors = 0;

  count_window_sampler dut (
    .clk           (clk),
    .rst           (rst),
    .count_in      (count_in),
    .start         (start),
    .stop          (stop),
    .window_len    (window_len),
    .clear_overrun (clear_overrun),
    .delta_data    (delta_data),
    .delta_valid   (delta_valid),
    .delta_ready   (delta_ready),
    .busy          (busy),
`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
    .peak_delta    (peak_delta),
    .peak_clear    (peak_clear),
`endif
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  // One clock; the upstream count then advances by inc.
  task automatic tick();
    @(posedge clk);
    #1;
    count_in = count_in + inc;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
    checks++; if (delta_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", delta_valid); end
    checks++; if (delta_data !== 32'd0) begin errors++; $display("FAIL rst_data got %0h exp 0", delta_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %b exp 0", overrun); end
`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
    checks++; if (peak_delta !== 32'd0) begin errors++; $display("FAIL rst_peak got %0d exp 0", peak_delta); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic ev;
    count_in = 32'd100; inc = 32'd1; window_len = 24'd4; delta_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy); end
    for (int i = 1; i <= 8; i++) begin
      tick();
      ev = (i % 4 == 0);
      checks++; if (delta_valid !== ev) begin errors++; $display("FAIL basic_valid c%0d got %b exp %b", i, delta_valid, ev); end
      if (ev) begin
        checks++; if (delta_data !== 32'd4) begin errors++; $display("FAIL basic_data c%0d got %0d exp 4", i, delta_data); end
      end
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_stop_busy got %b exp 0", busy); end
    checks++; if (delta_valid !== 1'b0) begin errors++; $display("FAIL basic_stop_valid got %b exp 0", delta_valid); end
  endtask

  task automatic test_wrap();
    count_in = 32'hFFFF_FFFE; inc = 32'd1; window_len = 24'd5; delta_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++; if (delta_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b exp 1", delta_valid); end
    checks++; if (delta_data !== 32'd5) begin errors++; $display("FAIL wrap_data got %0d exp 5", delta_data); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic test_overrun();
    count_in = 32'd0; inc = 32'd1; window_len = 24'd2; delta_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    checks++; if (delta_valid !== 1'b1 || delta_data !== 32'd2) begin errors++; $display("FAIL ovr_first got v%b d%0d exp v1 d2", delta_valid, delta_data); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_early got %b exp 0", overrun); end
    tick(); tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (delta_data !== 32'd2) begin errors++; $display("FAIL ovr_hold1 got %0d exp 2", delta_data); end
    tick(); tick();
    checks++; if (delta_valid !== 1'b1 || delta_data !== 32'd2) begin errors++; $display("FAIL ovr_hold2 got v%b d%0d exp v1 d2", delta_valid, delta_data); end
    delta_ready = 1'b1;
    tick();
    checks++; if (delta_valid !== 1'b0) begin errors++; $display("FAIL ovr_xfer got %b exp 0", delta_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
    tick();
    checks++; if (delta_valid !== 1'b1) begin errors++; $display("FAIL ovr_reload got %b exp 1", delta_valid); end
    clear_overrun = 1'b1;
    tick();
    clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", overrun); end
    tick();
    delta_ready = 1'b0;
    tick();
    clear_overrun = 1'b1;
    tick();
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set_wins got %b exp 1", overrun); end
    stop = 1'b1; delta_ready = 1'b1;
    tick();
    stop = 1'b0; clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL ovr_end got o%b b%b exp o0 b0", overrun, busy); end
  endtask

  task automatic test_stop();
    logic seen;
    count_in = 32'd0; inc = 32'd1; window_len = 24'd8; delta_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || delta_valid !== 1'b0) begin errors++; $display("FAIL stop_mid got b%b v%b exp b0 v0", busy, delta_valid); end
    seen = 1'b0;
    repeat (12) begin tick(); seen = seen | delta_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL stop_nosample got %b exp 0", seen); end
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (7) tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stop_end_busy got %b exp 0", busy); end
    checks++; if (delta_valid !== 1'b1 || delta_data !== 32'd8) begin errors++; $display("FAIL stop_end_sample got v%b d%0d exp v1 d8", delta_valid, delta_data); end
    tick();
    checks++; if (delta_valid !== 1'b0) begin errors++; $display("FAIL stop_end_drain got %b exp 0", delta_valid); end
  endtask

  task automatic test_len0();
    count_in = 32'd50; inc = 32'd3; window_len = 24'd0; delta_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    window_len = 24'd4;
    tick();
    checks++; if (delta_valid !== 1'b1 || delta_data !== 32'd3) begin errors++; $display("FAIL len0_a got v%b d%0d exp v1 d3", delta_valid, delta_data); end
    inc = 32'd5;
    tick();
    checks++; if (delta_data !== 32'd3) begin errors++; $display("FAIL len0_b got %0d exp 3", delta_data); end
    tick();
    checks++; if (delta_data !== 32'd5) begin errors++; $display("FAIL len0_c got %0d exp 5", delta_data); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++; if (delta_valid !== 1'b1 || delta_data !== 32'd5) begin errors++; $display("FAIL len0_restart got v%b d%0d exp v1 d5", delta_valid, delta_data); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    checks++; if (busy !== 1'b0 || delta_valid !== 1'b1) begin errors++; $display("FAIL len0_stop got b%b v%b exp b0 v1", busy, delta_valid); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic seen;
    count_in = 32'd0; inc = 32'd1; window_len = 24'd4; delta_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    checks++; if (delta_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL rmid_pre got v%b o%b exp v1 o1", delta_valid, overrun); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (delta_valid !== 1'b0 || overrun !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rmid_post got v%b o%b b%b exp 000", delta_valid, overrun, busy); end
    checks++; if (delta_data !== 32'd0) begin errors++; $display("FAIL rmid_data got %0d exp 0", delta_data); end
    delta_ready = 1'b1;
    seen = 1'b0;
    repeat (8) begin tick(); seen = seen | delta_valid; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_nosample got %b exp 0", seen); end
  endtask

`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
  task automatic test_peak();
    count_in = 32'd10; inc = 32'd3; window_len = 24'd1; delta_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    inc = 32'd7;
    tick();
    inc = 32'd2;
    tick();
    tick();
    checks++; if (delta_data !== 32'd2) begin errors++; $display("FAIL peak_last got %0d exp 2", delta_data); end
    checks++; if (peak_delta !== 32'd7) begin errors++; $display("FAIL peak_max got %0d exp 7", peak_delta); end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    peak_clear = 1'b1;
    tick();
    peak_clear = 1'b0;
    checks++; if (peak_delta !== 32'd0) begin errors++; $display("FAIL peak_clear got %0d exp 0", peak_delta); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_overrun();
    test_stop();
    test_len0();
    test_reset_mid();
`ifdef COUNT_WINDOW_SAMPLER_PEAK_EN
    test_peak();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
